writeback_stage: RTL and testbench

Final stage of the five-stage MIPS pipeline, directly downstream of the memory stage. It captures the memory-stage results (load data, ALU result, destination register, write-back controls) into the MEM/WB pipeline register, honouring stall and flush. It aligns and extends sub-word load data, selects the register-file write value, and drives the register-file write port and the forwarding unit. A retired-instruction counter supports performance checks.

---
 rtl/writeback_stage_pkg.sv | 12 +
 rtl/writeback_stage_load_align.sv | 45 ++++
 rtl/writeback_stage.sv | 91 +++++++++
 tb/tb_writeback_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// rtl/writeback_stage_pkg.sv - shared load-size encodings and write-back constants
package writeback_stage_pkg;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int RETIRE_W_DEFAULT = 32;

endpackage

// File: rtl/writeback_stage_load_align.sv
// rtl/writeback_stage_load_align.sv - big-endian sub-word load alignment and misalign detect
module wb_load_align
    import writeback_stage_pkg::*;
(
    input  logic [31:0] readData,
    input  logic [1:0]  offset,
    input  logic [1:0]  loadSize,
    input  logic        loadUnsigned,
    output logic [31:0] alignedData,
    output logic        misalign
);

    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    always_comb begin
        alignedData = readData;
        misalign    = 1'b0;
        halfSel     = offset[1] ? readData[15:0] : readData[31:16];
        byteSel     = readData[31:24];
        case (offset)
            2'd0: byteSel = readData[31:24];
            2'd1: byteSel = readData[23:16];
            2'd2: byteSel = readData[15:8];
            2'd3: byteSel = readData[7:0];
            default: byteSel = readData[31:24];
        endcase

        case (loadSize)
            LS_HALF: begin
                alignedData = loadUnsigned ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
                misalign    = offset[0];
            end
            LS_BYTE: begin
                alignedData = loadUnsigned ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
            end
            // Reserved encoding 11 behaves as a word load
            default: begin
                alignedData = readData;
                misalign    = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register, write-back mux and retire counter
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int RETIRE_W = RETIRE_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Valid_in,
    input  logic [31:0]         ReadData,
    input  logic [31:0]         ALUResult_in,
    input  logic [4:0]          WriteReg_in,
    input  logic                RegWrite_in,
    input  logic                MemtoReg_in,
    input  logic [1:0]          LoadSize_in,
    input  logic                LoadUnsigned_in,
    input  logic                Stall,
    input  logic                Flush,
    output logic                RegWrite_out,
    output logic [4:0]          WriteReg_out,
    output logic [31:0]         WriteData_out,
    output logic                Valid_out,
    output logic                AddrErr_out,
    output logic [RETIRE_W-1:0] RetireCount
);

    logic [31:0]         alignedData;
    logic                misalign;
    logic                addrErrNext;
    logic                regWriteNext;
    logic [31:0]         writeDataNext;

    logic                validQ;
    logic                regWriteQ;
    logic [4:0]          writeRegQ;
    logic [31:0]         writeDataQ;
    logic                addrErrQ;
    logic [RETIRE_W-1:0] retireQ;

    wb_load_align u_align (
        .readData     (ReadData),
        .offset       (ALUResult_in[1:0]),
        .loadSize     (LoadSize_in),
        .loadUnsigned (LoadUnsigned_in),
        .alignedData  (alignedData),
        .misalign     (misalign)
    );

    // Final write enable and write data are resolved before the register so
    // every output leaves straight from a flop.
    always_comb begin
        addrErrNext   = misalign & MemtoReg_in & Valid_in;
        regWriteNext  = RegWrite_in & Valid_in & ~addrErrNext & (WriteReg_in != REG_ZERO);
        writeDataNext = MemtoReg_in ? alignedData : ALUResult_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validQ     <= 1'b0;
            regWriteQ  <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
            addrErrQ   <= 1'b0;
            retireQ    <= '0;
        end else begin
            // The instruction leaving the register retires, faulted or not
            if (!Stall && validQ) begin
                retireQ <= retireQ + RETIRE_W'(1);
            end
            if (Flush) begin
                validQ    <= 1'b0;
                regWriteQ <= 1'b0;
                addrErrQ  <= 1'b0;
            end else if (!Stall) begin
                validQ     <= Valid_in;
                regWriteQ  <= regWriteNext;
                writeRegQ  <= WriteReg_in;
                writeDataQ <= writeDataNext;
                addrErrQ   <= addrErrNext;
            end
        end
    end

    assign RegWrite_out  = regWriteQ;
    assign WriteReg_out  = writeRegQ;
    assign WriteData_out = writeDataQ;
    assign Valid_out     = validQ;
    assign AddrErr_out   = addrErrQ;
    assign RetireCount   = retireQ;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Valid_in;
    logic [31:0] ReadData;
    logic [31:0] ALUResult_in;
    logic [4:0]  WriteReg_in;
    logic        RegWrite_in;
    logic        MemtoReg_in;
    logic [1:0]  LoadSize_in;
    logic        LoadUnsigned_in;
    logic        Stall;
    logic        Flush;
    logic        RegWrite_out;
    logic [4:0]  WriteReg_out;
    logic [31:0] WriteData_out;
    logic        Valid_out;
    logic        AddrErr_out;
    logic [3:0]  RetireCount;

    writeback_stage #(.RETIRE_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .Valid_in        (Valid_in),
        .ReadData        (ReadData),
        .ALUResult_in    (ALUResult_in),
        .WriteReg_in     (WriteReg_in),
        .RegWrite_in     (RegWrite_in),
        .MemtoReg_in     (MemtoReg_in),
        .LoadSize_in     (LoadSize_in),
        .LoadUnsigned_in (LoadUnsigned_in),
        .Stall           (Stall),
        .Flush           (Flush),
        .RegWrite_out    (RegWrite_out),
        .WriteReg_out    (WriteReg_out),
        .WriteData_out   (WriteData_out),
        .Valid_out       (Valid_out),
        .AddrErr_out     (AddrErr_out),
        .RetireCount     (RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        regWrite;
        logic [4:0]  writeReg;
        logic [31:0] writeData;
        logic        addrErr;
        logic [3:0]  retire;
        logic        checkData;
    } exp_t;

    exp_t expQ[$];
    int nCompared = 0;
    int nFailed   = 0;

    // Reference state: what the write-back outputs should hold after each edge
    logic        mValid, mRegWrite, mAddrErr;
    logic [4:0]  mWriteReg;
    logic [31:0] mWriteData;
    int          mRetire;
    logic        mCheckData;

    function automatic logic [31:0] loadValue(logic [31:0] rd, logic [1:0] off, logic [1:0] ls, logic uns);
        int unsigned v;
        int o;
        o = int'(off);
        if (ls == 2'b10) begin
            v = (rd >> (8 * (3 - o))) & 32'hFF;
            if (!uns && v >= 128) v = v | 32'hFFFFFF00;
        end else if (ls == 2'b01) begin
            v = (rd >> ((o >= 2) ? 0 : 16)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic tick();
        exp_t e;
        logic err;
        int o;
        @(posedge clk);
        o = int'(ALUResult_in[1:0]);
        err = MemtoReg_in && Valid_in &&
              ((((LoadSize_in == 2'b00) || (LoadSize_in == 2'b11)) && o != 0) ||
               ((LoadSize_in == 2'b01) && (o % 2 == 1)));
        if (reset) begin
            mValid = 0; mRegWrite = 0; mAddrErr = 0; mWriteReg = 0; mWriteData = 0;
            mRetire = 0; mCheckData = 1;
        end else begin
            if (!Stall) mRetire = (mRetire + (mValid ? 1 : 0)) % 16;
            if (Flush) begin
                mValid = 0; mRegWrite = 0; mAddrErr = 0; mCheckData = 0;
            end else if (!Stall) begin
                mValid     = Valid_in;
                mAddrErr   = err;
                mRegWrite  = RegWrite_in && Valid_in && !err && (WriteReg_in != 0);
                mWriteReg  = WriteReg_in;
                mWriteData = MemtoReg_in ? loadValue(ReadData, ALUResult_in[1:0], LoadSize_in, LoadUnsigned_in)
                                         : ALUResult_in;
                mCheckData = Valid_in && !err;
            end
        end
        e.valid = mValid; e.regWrite = mRegWrite; e.writeReg = mWriteReg;
        e.writeData = mWriteData; e.addrErr = mAddrErr; e.retire = 4'(mRetire);
        e.checkData = mCheckData;
        expQ.push_back(e);
        #1;
    endtask

    task automatic issue(logic vin, logic [31:0] rd, logic [31:0] alu, logic [4:0] wr,
                         logic rw, logic m2r, logic [1:0] ls, logic uns);
        reset = 0; Stall = 0; Flush = 0;
        Valid_in = vin; ReadData = rd; ALUResult_in = alu; WriteReg_in = wr;
        RegWrite_in = rw; MemtoReg_in = m2r; LoadSize_in = ls; LoadUnsigned_in = uns;
        tick();
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("Valid_out", 32'(Valid_out), 32'(e.valid));
            check("RegWrite_out", 32'(RegWrite_out), 32'(e.regWrite));
            check("AddrErr_out", 32'(AddrErr_out), 32'(e.addrErr));
            check("RetireCount", 32'(RetireCount), 32'(e.retire));
            if (e.checkData) begin
                check("WriteReg_out", 32'(WriteReg_out), 32'(e.writeReg));
                check("WriteData_out", WriteData_out, e.writeData);
            end
        end
    end

    initial begin
        mValid = 0; mRegWrite = 0; mAddrErr = 0; mWriteReg = 0; mWriteData = 0;
        mRetire = 0; mCheckData = 0;
        reset = 1; Stall = 0; Flush = 0; Valid_in = 0; ReadData = 0; ALUResult_in = 0;
        WriteReg_in = 0; RegWrite_in = 0; MemtoReg_in = 0; LoadSize_in = 0; LoadUnsigned_in = 0;
        #1;
        tick();
        tick();

        issue(1, 32'hDEADBEEF, 32'h100, 5'd8, 1, 1, 2'b00, 0);
        issue(1, 32'h12F45678, 32'h101, 5'd9, 1, 1, 2'b10, 0);
        issue(1, 32'h12F45678, 32'h101, 5'd9, 1, 1, 2'b10, 1);
        issue(1, 32'h12F45678, 32'h103, 5'd9, 1, 1, 2'b10, 0);
        issue(1, 32'h00008001, 32'h102, 5'd10, 1, 1, 2'b01, 0);
        issue(1, 32'h00008001, 32'h101, 5'd10, 1, 1, 2'b01, 0);
        issue(1, 32'h0, 32'h0000002A, 5'd0, 1, 0, 2'b00, 0);
        issue(1, 32'h0, 32'h0000002A, 5'd3, 1, 0, 2'b00, 0);
        issue(1, 32'hCAFEF00D, 32'h204, 5'd11, 1, 1, 2'b11, 0);
        issue(0, 32'h0, 32'h55, 5'd12, 1, 0, 2'b00, 0);

        issue(1, 32'h11112222, 32'h77, 5'd4, 1, 0, 2'b00, 0);
        Stall = 1; Valid_in = 1; ALUResult_in = 32'h99; WriteReg_in = 5'd5;
        repeat (3) tick();
        Flush = 1;
        tick();
        Stall = 0; Flush = 0;
        tick();

        for (int i = 0; i < 6; i++) issue(1, 32'h0, 32'(i), 5'd7, 1, 0, 2'b00, 0);
        reset = 1; Stall = 1; Flush = 1;
        tick();
        for (int i = 0; i < 18; i++) issue(1, 32'h0, 32'(i + 100), 5'd6, 1, 0, 2'b00, 0);

        for (int i = 0; i < 400; i++) begin
            reset           = ($urandom_range(0, 99) < 2);
            Stall           = ($urandom_range(0, 99) < 20);
            Flush           = ($urandom_range(0, 99) < 10);
            Valid_in        = ($urandom_range(0, 99) < 85);
            ReadData        = $urandom;
            ALUResult_in    = $urandom;
            WriteReg_in     = 5'($urandom_range(0, 31));
            RegWrite_in     = ($urandom_range(0, 99) < 80);
            MemtoReg_in     = 1'($urandom_range(0, 1));
            LoadSize_in     = 2'($urandom_range(0, 3));
            LoadUnsigned_in = 1'($urandom_range(0, 1));
            tick();
        end

        reset = 0; Stall = 0; Flush = 0; Valid_in = 0;
        tick();
        repeat (4) @(negedge clk);
        if (expQ.size() != 0) begin
            nCompared++;
            nFailed++;
            $display("FAIL drain: %0d expected entries left, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
